freq_detect: RTL

- Receive-side counterpart of the selectable clock divider: measures the period of an incoming square wave in clk_in cycles.
- Classifies the measured period into one of the four divider bands and recovers the 2-bit select code that produced it.
- Sits on the far end of the divided-clock line, e.g. on a second board or as loopback self-check, and drives status LEDs/7-seg with the decoded select and lock state.

---
 rtl/freq_detect.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/freq_detect.sv
// Measures the period of an incoming square wave and recovers the divider band/select code.
// Optional DUTY_CHECK_EN: also measures high time and rejects non-50% duty as band_err/duty_err.
module freq_detect #(
  parameter int BASE_PERIOD = 4096,
  parameter int TOL         = 8,
  parameter int LOCK_CNT    = 3,
  parameter int CNT_W       = 14
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       sig_in,
  output logic [1:0] sel_out,
  output logic       meas_valid,
  output logic       band_err,
  output logic       locked,
`ifdef DUTY_CHECK_EN
  output logic       duty_err,
`endif
  output logic       no_signal
);

  localparam int SW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(2 * BASE_PERIOD);

  typedef enum logic {WAIT_EDGE, MEASURE} state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q, sel_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic             meas_q, berr_q, lock_q, nosig_q;
  logic             rise, band_hit, match;

  assign rise = s2_q & ~s3_q;

  // Period classification against the four band nominals, done on the rise cycle.
  always_comb begin
    int d;
    band_hit = 1'b0;
    sel_d    = sel_q;
    for (int k = 0; k < 4; k++) begin
      d = int'(cnt_q) - (BASE_PERIOD >> k);
      if (d <= TOL && d >= -TOL) begin
        band_hit = 1'b1;
        sel_d    = 2'(k);
      end
    end
  end

`ifdef DUTY_CHECK_EN
  logic [CNT_W-1:0] hcnt_q;
  logic             hrun_q, dty_q, duty_ok, fall;
  int               dd;

  assign fall = ~s2_q & s3_q;

  always_comb begin
    dd      = 2 * int'(hcnt_q) - int'(cnt_q);
    duty_ok = (dd <= 2 * TOL) && (dd >= -2 * TOL);
  end

  assign match    = band_hit & duty_ok;
  assign duty_err = dty_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcnt_q <= '0;
      hrun_q <= 1'b0;
      dty_q  <= 1'b0;
    end else begin
      dty_q <= (state_q == MEASURE) && rise && band_hit && !duty_ok;
      if (rise) begin
        hcnt_q <= CNT_W'(1);
        hrun_q <= 1'b1;
      end else if (hrun_q) begin
        if (fall)                hrun_q <= 1'b0;
        else if (hcnt_q != '1)   hcnt_q <= hcnt_q + 1'b1;
      end
    end
  end
`else
  assign match = band_hit;
`endif

  // A band change or a first match after an error starts a fresh streak.
  always_comb begin
    streak_d = '0;
    if (match) begin
      if (streak_q != '0 && sel_d == sel_q)
        streak_d = (streak_q == SW'(LOCK_CNT)) ? streak_q : streak_q + 1'b1;
      else
        streak_d = SW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= WAIT_EDGE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
      streak_q <= '0;
      meas_q   <= 1'b0;
      berr_q   <= 1'b0;
      lock_q   <= 1'b0;
      nosig_q  <= 1'b0;
    end else begin
      s1_q   <= sig_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      meas_q <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        WAIT_EDGE: begin
          cnt_q <= '0;
          if (rise) begin
            cnt_q   <= CNT_W'(1);
            state_q <= MEASURE;
            nosig_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt_q    <= CNT_W'(1);
            meas_q   <= match;
            berr_q   <= ~match;
            if (match) sel_q <= sel_d;
            streak_q <= streak_d;
            lock_q   <= (streak_d == SW'(LOCK_CNT));
          end else if (cnt_q == TMO) begin
            state_q  <= WAIT_EDGE;
            cnt_q    <= '0;
            nosig_q  <= 1'b1;
            lock_q   <= 1'b0;
            streak_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= WAIT_EDGE;
      endcase
    end
  end

  assign sel_out    = sel_q;
  assign meas_valid = meas_q;
  assign band_err   = berr_q;
  assign locked     = lock_q;
  assign no_signal  = nosig_q;

endmodule
